alu_arbiter: RTL

//  Shares the single combinational ALU between two requesters: req0 (execute stage) and req1 (branch-compare/address unit).

---
 rtl/alu_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 12 +
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encodings and flag bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RESP_LO = 2'd2,
    ST_RESP_HI = 2'd3
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: ptr=0 favours requester 0, ptr=1 favours requester 1.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone valid always wins; the pointer only breaks ties.
  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant and a beat-based response channel.
// Define ALU_ARB_PERF_EN to add saturating per-requester accepted-op counters (perf_ops0/perf_ops1).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPC_W = 3,
  parameter int FC_W  = 4
`ifdef ALU_ARB_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_inp1,
  input  logic [WIDTH-1:0] req0_inp2,
  input  logic [OPC_W-1:0] req0_opcode,
  input  logic [FC_W-1:0]  req0_fcode,
  input  logic             req0_wide,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_inp1,
  input  logic [WIDTH-1:0] req1_inp2,
  input  logic [OPC_W-1:0] req1_opcode,
  input  logic [FC_W-1:0]  req1_fcode,
  input  logic             req1_wide,
  output logic [WIDTH-1:0] alu_inp1,
  output logic [WIDTH-1:0] alu_inp2,
  output logic [OPC_W-1:0] alu_opcode,
  output logic [FC_W-1:0]  alu_fcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_ext_out,
  input  logic             alu_cflag,
  input  logic             alu_zflag,
  input  logic             alu_sflag,
  input  logic             alu_oflag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       flags_q
`ifdef ALU_ARB_PERF_EN
  , output logic [PERF_W-1:0] perf_ops0
  , output logic [PERF_W-1:0] perf_ops1
`endif
);

  state_t           state, state_next;
  logic [1:0]       grant;
  logic             accept;
  logic             ptr_q, id_q, wide_q;
  logic [WIDTH-1:0] inp1_q, inp2_q, out_q, ext_q;
  logic [OPC_W-1:0] opc_q;
  logic [FC_W-1:0]  fc_q;
  logic [3:0]       op_flags_q;
  logic [3:0]       alu_flags;

  rr_arb2 u_rr_arb2 (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign accept    = (state == ST_IDLE) && (|grant);
  assign alu_flags = {alu_oflag, alu_sflag, alu_zflag, alu_cflag};

  assign alu_inp1   = inp1_q;
  assign alu_inp2   = inp2_q;
  assign alu_opcode = opc_q;
  assign alu_fcode  = fc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Response fields come straight from the result registers, so they stay stable while stalled.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    rsp_flags  = '0;
    case (state)
      ST_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (|grant) state_next = ST_EXEC;
      end
      ST_EXEC: state_next = ST_RESP_LO;
      ST_RESP_LO: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = out_q;
        rsp_last  = ~wide_q;
        rsp_flags = op_flags_q;
        if (rsp_ready) state_next = wide_q ? ST_RESP_HI : ST_IDLE;
      end
      ST_RESP_HI: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = ext_q;
        rsp_last  = 1'b1;
        rsp_flags = op_flags_q;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Only the execute-stage requester owns the architectural flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      wide_q     <= 1'b0;
      inp1_q     <= '0;
      inp2_q     <= '0;
      opc_q      <= '0;
      fc_q       <= '0;
      out_q      <= '0;
      ext_q      <= '0;
      op_flags_q <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        ptr_q  <= grant[0];
        id_q   <= grant[1];
        wide_q <= grant[1] ? req1_wide   : req0_wide;
        inp1_q <= grant[1] ? req1_inp1   : req0_inp1;
        inp2_q <= grant[1] ? req1_inp2   : req0_inp2;
        opc_q  <= grant[1] ? req1_opcode : req0_opcode;
        fc_q   <= grant[1] ? req1_fcode  : req0_fcode;
      end
      if (state == ST_EXEC) begin
        out_q      <= alu_out;
        ext_q      <= alu_ext_out;
        op_flags_q <= alu_flags;
        if (!id_q) flags_q <= alu_flags;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops0 <= '0;
      perf_ops1 <= '0;
    end else begin
      if (accept && grant[0] && (perf_ops0 != {PERF_W{1'b1}})) perf_ops0 <= perf_ops0 + 1'b1;
      if (accept && grant[1] && (perf_ops1 != {PERF_W{1'b1}})) perf_ops1 <= perf_ops1 + 1'b1;
    end
  end
`endif

endmodule
